uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
//
// PURPOSE
//   Parametrised UART transmitter with an input FIFO and a valid/ready write interface.
//   It serialises words of DATA_BITS bits with configurable parity and stop bits.
//   Successor to the fixed 8-bit free-running transmitter: it adds buffering,
//   back-pressure, data-width and parity-mode selection, and a reset.
//   It sits between a byte/word producer in the fabric and the board UART pin.
//
// PARAMETERS
//   CLKS_PER_BIT  234    clk cycles per UART bit; must be >= 2
//   DATA_BITS     8      payload width, legal range 5..9
//   PARITY        2'b00  00 none, 01 odd, 10 even, 11 mark (always 1)
//   STOP_BITS     1'b0   0 = one stop bit, 1 = two stop bits
//   FIFO_DEPTH    16     FIFO entries; power of 2, >= 2
//
// PORTS
//   clk        in   1                        system clock, all logic on rising edge
//   rst_n      in   1                        asynchronous active-low reset
//   inData     in   DATA_BITS                word to transmit
//   inValid    in   1                        producer has a word on inData
//   inReady    out  1                        FIFO can accept; write when inValid && inReady
//   dataOut    out  1                        serial line, idle high
//   busy       out  1                        a frame is in progress
//   fifoLevel  out  $clog2(FIFO_DEPTH)+1     words queued, excluding the one being shifted
//
// BEHAVIOUR
//   - Reset (rst_n low, async): dataOut=1, busy=0, inReady=1, fifoLevel=0.
//     The FSM enters IDLE and the FIFO is emptied. Reset mid-frame aborts the frame at once;
//     no partial frame resumes after release.
//   - Write: the word is accepted on a clk edge where inValid && inReady.
//     inReady = (fifoLevel < FIFO_DEPTH), registered-combinational from the level only.
//     inReady does not depend on inValid.
//   - Push and pop in the same cycle: fifoLevel is unchanged. FIFO order is strict first-in, first-out.
//   - FSM states: IDLE, START, DATA, PAR, STOP.
//     - IDLE: dataOut=1, busy=0. If the FIFO is non-empty, pop the head into the shift register
//       and go to START.
//     - START: dataOut=0 for CLKS_PER_BIT cycles, then go to DATA.
//     - DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles.
//       Go to PAR if PARITY != 00, else to STOP.
//     - PAR: one bit. Odd: ~^data. Even: ^data. Mark: 1.
//     - STOP: dataOut=1 for CLKS_PER_BIT*(1+STOP_BITS) cycles.
//   - Back-to-back frames: on the last cycle of STOP, if the FIFO is non-empty, pop and go
//     directly to START. There is zero idle cycles between frames.
//     If the FIFO is empty, go to IDLE.
//   - Latency: a word accepted on edge k into an empty FIFO with the FSM in IDLE drives
//     dataOut low from edge k+2.
//   - busy: high from the pop edge through the last STOP cycle.
//     It stays continuously high across back-to-back frames.
//   - Frame length: CLKS_PER_BIT*(2 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles.
//   - Timing outputs: dataOut and busy are registered (glitch-free on the pin).
//     The bit counter wraps only via the FSM, never by overflow.
//   - Width rules: inData bits above DATA_BITS do not exist. The baud counter is
//     $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and reloads to 0.
//
// TESTING
//   Bench settings: CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated otherwise.
//   1. Reset check: hold rst_n low, then release.
//      -> dataOut=1, busy=0, inReady=1, fifoLevel=0; the line stays high with no writes.
//   2. Single word: write 8'hA5 with PARITY=00 and one stop bit.
//      -> dataOut shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high for exactly 40 cycles.
//   3. Parity and stop bits: write 8'h07 with PARITY=10 (even) and STOP_BITS=1.
//      -> parity bit=1, two stop bits, 48-cycle frame. With PARITY=01 -> parity bit=0.
//      With PARITY=11 -> parity bit=1.
//   4. Fill the FIFO: hold inValid high over 6 consecutive words.
//      -> exactly 5 words are accepted before inReady drops (1 popped + 4 queued).
//      The frames go out in order with no idle gap, busy never deasserts, and
//      fifoLevel returns to 0.
//   5. Simultaneous push and pop: write a word on the exact edge of the STOP-to-START pop
//      with fifoLevel=2 -> fifoLevel stays at 2 and no word is lost or duplicated.
//   6. Reset mid-frame: pull rst_n low during data bit 3 with 2 words queued.
//      -> dataOut=1 with no clock edge, fifoLevel=0, and no frame appears after release.
//   7. Width: DATA_BITS=5, write 5'h13.
//      -> 7-bit frame 0,1,1,0,0,1,1 (start bit, payload bits, stop bit).

Source files
------------

// File: rtl/uart_tx_buffered_if.sv
// Write-side handshake of the buffered UART transmitter.
// The producer drives data/valid; the transmitter returns ready.
interface uart_tx_buffered_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] inData;
    logic                 inValid;
    logic                 inReady;

    modport master (output inData, inValid, input inReady);
    modport slave  (input inData, inValid, output inReady);
endinterface

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed by a small FIFO: start, DATA_BITS payload (LSB first),
// optional parity, one or two stop bits. Frames run back to back while data is queued.
module uart_tx_buffered #(
    parameter int         CLKS_PER_BIT = 234,
    parameter int         DATA_BITS    = 8,
    parameter logic [1:0] PARITY       = 2'b00,
    parameter logic       STOP_BITS    = 1'b0,
    parameter int         FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uart_tx_buffered_if.slave             wr,
    output logic                          dataOut,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bitcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic                 push, pop, cnt_last, stop_last;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        case (PARITY)
            2'b01:   return ~^d;
            2'b10:   return ^d;
            default: return 1'b1;
        endcase
    endfunction

    assign wr.inReady = (fifoLevel < FULL);
    assign push       = wr.inValid && wr.inReady;
    assign cnt_last   = (cnt == CNT_LAST);
    assign stop_last  = (state == STOP) && cnt_last && (bitcnt == STOP_LAST);
    // The head is taken either from idle or on the final stop cycle, so frames abut.
    assign pop        = (fifoLevel != '0) && ((state == IDLE) || stop_last);

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr.inData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            fifoLevel <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   fifoLevel <= fifoLevel + 1'b1;
                2'b01:   fifoLevel <= fifoLevel - 1'b1;
                default: fifoLevel <= fifoLevel;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            dataOut <= 1'b1;
            busy    <= 1'b0;
        end else begin
            // Pin value is registered from the state of the cycle just ended.
            case (state)
                START:   dataOut <= 1'b0;
                DATA:    dataOut <= shreg[0];
                PAR:     dataOut <= par_bit;
                default: dataOut <= 1'b1;
            endcase

            if (state == IDLE || cnt_last) cnt <= '0;
            else                           cnt <= cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= mem[rptr];
                        par_bit <= parity_of(mem[rptr]);
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (cnt_last) begin
                        bitcnt <= '0;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        shreg <= shreg >> 1;
                        if (bitcnt == BIT_LAST) begin
                            bitcnt <= '0;
                            state  <= (PARITY != 2'b00) ? PAR : STOP;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (cnt_last) begin
                        bitcnt <= '0;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (cnt_last) begin
                        if (bitcnt == STOP_LAST) begin
                            bitcnt <= '0;
                            if (pop) begin
                                shreg   <= mem[rptr];
                                par_bit <= parity_of(mem[rptr]);
                                state   <= START;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: five parameter variants, frame table, FIFO corner
// sequences, and a random stream checked by a UART receiver model plus scoreboard.
module tb_uart_tx_buffered;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int NI    = 5;

    localparam int         DB_T  [NI] = '{8, 8, 8, 8, 5};
    localparam logic [1:0] PAR_T [NI] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
    localparam logic       STB_T [NI] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [8:0]    wdata [NI];
    logic [NI-1:0] wvalid = '0;
    logic [NI-1:0] dout, bsy, rdy;
    logic [2:0]    lvl [NI];

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : gi
            uart_tx_buffered_if #(.DATA_BITS(DB_T[g])) bus ();
            assign bus.inData  = wdata[g][DB_T[g]-1:0];
            assign bus.inValid = wvalid[g];
            assign rdy[g]      = bus.inReady;
            uart_tx_buffered #(
                .CLKS_PER_BIT(CPB), .DATA_BITS(DB_T[g]), .PARITY(PAR_T[g]),
                .STOP_BITS(STB_T[g]), .FIFO_DEPTH(DEPTH)
            ) dut (
                .clk(clk), .rst_n(rst_n), .wr(bus),
                .dataOut(dout[g]), .busy(bsy[g]), .fifoLevel(lvl[g])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Receiver model on instance 0 (8 data bits, no parity, one stop): mid-bit sampling.
    logic [7:0] rxq [$];
    int         framing_err = 0;
    logic [7:0] mon_w;
    always begin
        @(negedge clk);
        if (rst_n && dout[0] === 1'b0) begin
            repeat (CPB/2) @(negedge clk);
            if (dout[0] !== 1'b0) framing_err++;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_w[i] = dout[0];
            end
            repeat (CPB) @(negedge clk);
            if (dout[0] !== 1'b1) framing_err++;
            rxq.push_back(mon_w);
        end
    end

    typedef struct {
        int         inst;
        logic [8:0] data;
        int         nbits;
        logic [11:0] frame;   // line order read left to right, right-aligned
    } vec_t;
    vec_t tab [11];

    logic [7:0]  expq [$];
    logic [7:0]  words [6];
    logic [11:0] got;
    int n, len, busy_cnt, stable, cnt, acc, first_low, sent, cyc;
    logic v, r;

    task automatic wait_idle(input int k);
        int t = 0;
        while ((bsy[k] !== 1'b0 || lvl[k] !== 3'd0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", (t < 2000), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rx(input int want, input int budget);
        int t = 0;
        while (rxq.size() < want && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("rx_count", rxq.size(), want);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) wdata[i] = '0;

        tab[0]  = '{0, 9'h0A5, 10, 12'b00_0_10100101_1};
        tab[1]  = '{1, 9'h007, 12, 12'b0_11100000_1_11};
        tab[2]  = '{2, 9'h007, 11, 12'b0_0_11100000_0_1};
        tab[3]  = '{3, 9'h007, 11, 12'b0_0_11100000_1_1};
        tab[4]  = '{4, 9'h013,  7, 12'b00000_0_11001_1};
        tab[5]  = '{0, 9'h0FF, 10, 12'b00_0_11111111_1};
        tab[6]  = '{1, 9'h000, 12, 12'b0_00000000_0_11};
        tab[7]  = '{2, 9'h000, 11, 12'b0_0_00000000_1_1};
        tab[8]  = '{4, 9'h00A,  7, 12'b00000_0_01010_1};
        tab[9]  = '{1, 9'h080, 12, 12'b0_00000001_1_11};
        tab[10] = '{3, 9'h000, 11, 12'b0_0_00000000_1_1};

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk($sformatf("reset_state%0d", i), {dout[i], bsy[i], rdy[i], lvl[i]}, {1'b1, 1'b0, 1'b1, 3'd0});
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (dout !== '1 || bsy !== '0) cnt++;
        end
        chk("idle_line_after_reset", cnt, 0);

        // Single frames from the table
        for (int t = 0; t < 11; t++) begin
            n   = tab[t].inst;
            len = tab[t].nbits * CPB;
            @(negedge clk);
            wdata[n] = tab[t].data;
            wvalid[n] = 1'b1;
            chk($sformatf("row%0d_ready", t), rdy[n], 1);
            @(posedge clk);
            @(negedge clk);
            wvalid[n] = 1'b0;
            chk($sformatf("row%0d_after_accept", t), {dout[n], bsy[n]}, 2'b10);
            @(negedge clk);
            chk($sformatf("row%0d_pop_edge", t), {dout[n], bsy[n]}, 2'b11);
            busy_cnt = 1;
            stable = 1;
            got = '0;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                if (c < len - 1) busy_cnt += int'(bsy[n]);
                if (c % CPB == 0) got[tab[t].nbits - 1 - c / CPB] = dout[n];
                else if (dout[n] !== got[tab[t].nbits - 1 - c / CPB]) stable = 0;
            end
            chk($sformatf("row%0d_busy_end", t), bsy[n], 0);
            chk($sformatf("row%0d_frame", t), got, tab[t].frame);
            chk($sformatf("row%0d_busy_len", t), busy_cnt, len);
            chk($sformatf("row%0d_bit_width", t), stable, 1);
            @(negedge clk);
            chk($sformatf("row%0d_idle", t), dout[n], 1);
        end

        // Fill the FIFO with valid held high over six words
        wait_idle(0);
        rxq.delete();
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            wvalid[0] = 1'b1;
            wdata[0]  = {1'b0, words[acc]};
            r = rdy[0];
            if (c == 5) chk("fill_ready_low", r, 0);
            @(posedge clk);
            if (r) acc++;
        end
        @(negedge clk);
        wvalid[0] = 1'b0;
        chk("fill_accepted", acc, 5);
        chk("fill_level", lvl[0], 4);
        first_low = -1;
        for (int j = 0; j < 400; j++) begin
            if (bsy[0] == 1'b0) begin
                first_low = j;
                break;
            end
            @(negedge clk);
        end
        chk("fill_busy_continuous", first_low, 196);
        wait_rx(5, 100);
        for (int i = 0; i < 5 && i < rxq.size(); i++)
            chk($sformatf("fill_order%0d", i), rxq[i], words[i]);
        chk("fill_level_drained", lvl[0], 0);

        // Push on the exact STOP->START pop edge with two words queued
        wait_idle(0);
        rxq.delete();
        words = '{8'hC1, 8'h3E, 8'h9D, 8'h42, 8'h00, 8'h00};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wvalid[0] = 1'b1;
            wdata[0]  = {1'b0, words[c]};
            @(posedge clk);
        end
        @(negedge clk);
        wvalid[0] = 1'b0;
        repeat (38) @(negedge clk);
        chk("pp_level_before", lvl[0], 2);
        wvalid[0] = 1'b1;
        wdata[0]  = {1'b0, words[3]};
        chk("pp_ready", rdy[0], 1);
        @(posedge clk);
        @(negedge clk);
        wvalid[0] = 1'b0;
        chk("pp_level_after", lvl[0], 2);
        chk("pp_busy", bsy[0], 1);
        wait_rx(4, 300);
        for (int i = 0; i < 4 && i < rxq.size(); i++)
            chk($sformatf("pp_order%0d", i), rxq[i], words[i]);

        // Reset in the middle of data bit 3 with two words queued
        wait_idle(0);
        words = '{8'h00, 8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wvalid[0] = 1'b1;
            wdata[0]  = {1'b0, words[c]};
            @(posedge clk);
        end
        @(negedge clk);
        wvalid[0] = 1'b0;
        chk("rst_mid_level_before", lvl[0], 2);
        repeat (17) @(negedge clk);
        chk("rst_mid_line_low", dout[0], 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_async", {dout[0], bsy[0], rdy[0], lvl[0]}, {1'b1, 1'b0, 1'b1, 3'd0});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (dout[0] !== 1'b1 || bsy[0] !== 1'b0) cnt++;
        end
        chk("rst_mid_no_resume", cnt, 0);
        rxq.delete();
        framing_err = 0;

        // Random stream against the scoreboard and receiver model
        expq.delete();
        sent = 0;
        cyc = 0;
        cnt = 0;
        while (sent < 40 && cyc < 20000) begin
            @(negedge clk);
            v = ($urandom_range(0, 3) != 0);
            wvalid[0] = v;
            wdata[0]  = {1'b0, 8'($urandom_range(0, 255))};
            r = rdy[0];
            if (r !== (lvl[0] < 3'(DEPTH)) || lvl[0] > 3'(DEPTH)) cnt++;
            @(posedge clk);
            if (v && r) begin
                expq.push_back(wdata[0][7:0]);
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        wvalid[0] = 1'b0;
        chk("rand_sent", sent, 40);
        chk("rand_ready_vs_level", cnt, 0);
        wait_rx(expq.size(), 5000);
        for (int i = 0; i < expq.size() && i < rxq.size(); i++)
            chk($sformatf("rand_word%0d", i), rxq[i], expq[i]);
        chk("rand_framing", framing_err, 0);
        wait_idle(0);
        chk("rand_final", {dout[0], bsy[0], lvl[0]}, {1'b1, 1'b0, 3'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
